alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 2, number of EXEC cycles for MUL/MULI (range 1..4); all other ops take 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  issue request carries a valid operation.
REQ-005 in_ready  output  1  sequencer accepts the operation this cycle.
REQ-006 in_oper / in_func / in_cond  input  4/4/4  opcode, function and condition fields.
REQ-007 in_dst / in_src  input  16/16  operand values; in_wreg  input  4  destination register index.
REQ-008 alu_dst, alu_src  output  16/16; alu_oper, alu_func, alu_cond  output  4/4/4; alu_psr  output  5  drive ALU inputs.
REQ-009 alu_result  input  16; alu_psr_wr  input  5; alu_psr_en  input  5  ALU outputs, {C,L,F,Z,N} order.
REQ-010 out_valid  output  1; out_ready  input  1  result handshake.
REQ-011 out_result  output  16; out_wreg  output  4; out_wr  output  1 (register writeback); out_pc  output  1 (result is new PC).
REQ-012 psr  output  5  architectural flags {C,L,F,Z,N}.

Function
REQ-013 FSM states IDLE, EXEC, DONE; transfer on in_valid & in_ready, out_valid & out_ready.
REQ-014 in_ready = 1 in IDLE, = out_ready in DONE, 0 in EXEC.
REQ-015 Accept: register oper/func/cond/dst/src/wreg into operand registers, load cycle counter, go to EXEC.
REQ-016 alu_* outputs driven only from operand registers; alu_psr = psr register; all stable throughout EXEC.
REQ-017 Counter loads MUL_CYCLES-1 for oper 1110 or (oper 0000, func 1110), else 0; decrements each EXEC cycle.
REQ-018 EXEC with counter 0: capture alu_result into out_result, update psr bitwise (psr[i] <= alu_psr_en[i] ? alu_psr_wr[i] : psr[i]), go to DONE.
REQ-019 EXEC with counter > 0: no capture, no psr update, stay in EXEC.
REQ-020 Latency accept->out_valid: 2 cycles (1 + MUL_CYCLES for multiply).
REQ-021 DONE: out_valid = 1; out_result/out_wreg/out_wr/out_pc held until out_ready.
REQ-022 DONE & out_ready & in_valid: new op accepted same cycle, go to EXEC (back-to-back, one op per 2 cycles); without in_valid go to IDLE.
REQ-023 out_wr = 0 for CMPI (1011), BCOND (1100), REGISTER with func CMP (1011) or TEST (1111), SPECIAL with func JCOND (1100); else 1.
REQ-024 out_pc = 1 for BCOND and SPECIAL/JCOND, else 0.
REQ-025 Next op's alu_psr reflects previous op's psr update (no bypass needed; update precedes next EXEC).
REQ-026 in_valid while in EXEC is ignored; requester holds fields until in_ready.

Reset
REQ-027 reset: state IDLE, psr = 0, out_valid = 0, out_result = 0, out_wreg = 0, out_wr = 0, out_pc = 0, operand registers = 0, counter = 0.
REQ-028 reset during EXEC or DONE aborts the op: no psr update, no out_valid, in_ready = 1 on following cycle.
REQ-029 reset dominates simultaneous in_valid; no operation accepted in reset cycle.

Structure
REQ-030 Opcode, REGISTER/SPECIAL func codes, PSR bit indices and FSM state encoding SHALL live in a shared package used by alu and alu_seq.
REQ-031 One sub-module: alu_seq_dec (combinational decode of out_wr, out_pc, multiply detect); no ALU instance inside alu_seq.

Verification
REQ-032 ADD (0000/0101), dst=0x7FFF src=0x0001, psr=0 -> out_valid 2 cycles after accept, out_result=0x8000, psr=F,N set, C=0, out_wr=1.
REQ-033 MULI (1110), MUL_CYCLES=2, dst=0x0003 src=0x0005 -> out_valid 3 cycles after accept, out_result=0x000F, psr unchanged.
REQ-034 CMPI dst=0x0002 src=0x0005 then BCOND cond EQ -> CMPI out_wr=0, L/N written; BCOND alu_psr equals post-CMPI psr, out_pc=1, out_wr=0.
REQ-035 Two ADDs, out_ready held low 3 cycles -> first result stable 3 cycles, in_ready=0; release -> second accepted same cycle as first retires.
REQ-036 reset asserted in EXEC of SUB with psr=0x1F -> psr=0, out_valid stays 0, in_ready=1 next cycle.
REQ-037 ADDC with psr C=1, dst=0xFFFF src=0x0000 -> alu_psr C=1 during EXEC, out_result=0x0000, C=1, Z updated per alu_psr_en.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU and its issue sequencer: opcodes, function codes,
// PSR bit positions, sequencer state encoding and the latched-operation record.
package alu_seq_pkg;

  localparam int DATA_W  = 16;
  localparam int FIELD_W = 4;
  localparam int PSR_W   = 5;
  localparam int CNT_W   = 2;

  // Primary opcodes
  localparam logic [FIELD_W-1:0] OP_REGISTER = 4'b0000;
  localparam logic [FIELD_W-1:0] OP_SPECIAL  = 4'b0100;
  localparam logic [FIELD_W-1:0] OP_ADDI     = 4'b0101;
  localparam logic [FIELD_W-1:0] OP_ADDCI    = 4'b0111;
  localparam logic [FIELD_W-1:0] OP_SUBI     = 4'b1001;
  localparam logic [FIELD_W-1:0] OP_CMPI     = 4'b1011;
  localparam logic [FIELD_W-1:0] OP_BCOND    = 4'b1100;
  localparam logic [FIELD_W-1:0] OP_MULI     = 4'b1110;

  // Function codes under OP_REGISTER
  localparam logic [FIELD_W-1:0] FN_ADD  = 4'b0101;
  localparam logic [FIELD_W-1:0] FN_ADDC = 4'b0111;
  localparam logic [FIELD_W-1:0] FN_SUB  = 4'b1001;
  localparam logic [FIELD_W-1:0] FN_CMP  = 4'b1011;
  localparam logic [FIELD_W-1:0] FN_MUL  = 4'b1110;
  localparam logic [FIELD_W-1:0] FN_TEST = 4'b1111;

  // Function codes under OP_SPECIAL
  localparam logic [FIELD_W-1:0] SF_JCOND = 4'b1100;

  // PSR layout is {C,L,F,Z,N}, MSB first
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] oper;
    logic [FIELD_W-1:0] func;
    logic [FIELD_W-1:0] cond;
    logic [DATA_W-1:0]  dst;
    logic [DATA_W-1:0]  src;
    logic [FIELD_W-1:0] wreg;
    logic               wr;
    logic               pc;
  } op_t;

  // Each flag is either rewritten by the ALU or kept, independently of the others.
  function automatic logic [PSR_W-1:0] psr_merge(input logic [PSR_W-1:0] cur,
                                                  input logic [PSR_W-1:0] wr,
                                                  input logic [PSR_W-1:0] en);
    logic [PSR_W-1:0] res;
    for (int i = 0; i < PSR_W; i++) begin
      res[i] = en[i] ? wr[i] : cur[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_seq_dec.sv
// Combinational opcode decode for the sequencer: register writeback, PC load and
// multi-cycle multiply detection.
module alu_seq_dec
  import alu_seq_pkg::*;
(
  input  logic [FIELD_W-1:0] oper_i,
  input  logic [FIELD_W-1:0] func_i,
  output logic               wr_o,
  output logic               pc_o,
  output logic               mul_o
);

  logic reg_no_wb;
  logic special_jcond;

  // NOTE: every output is assigned on every path through this block, so no latch can be inferred.
  always_comb begin
    special_jcond = (oper_i == OP_SPECIAL) && (func_i == SF_JCOND);
    reg_no_wb     = (oper_i == OP_REGISTER) && ((func_i == FN_CMP) || (func_i == FN_TEST));
    pc_o          = (oper_i == OP_BCOND) || special_jcond;
    // Compares only set flags; branches and jumps redirect the PC instead of a register.
    wr_o          = !((oper_i == OP_CMPI) || pc_o || reg_no_wb);
    mul_o         = (oper_i == OP_MULI) || ((oper_i == OP_REGISTER) && (func_i == FN_MUL));
  end

endmodule

// File: rtl/alu_seq.sv
// Issue sequencer for an external combinational ALU: latches one operation, holds
// the ALU inputs stable for its execution cycles, then captures result and flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_oper,
  input  logic [FIELD_W-1:0] in_func,
  input  logic [FIELD_W-1:0] in_cond,
  input  logic [DATA_W-1:0]  in_dst,
  input  logic [DATA_W-1:0]  in_src,
  input  logic [FIELD_W-1:0] in_wreg,
  output logic [DATA_W-1:0]  alu_dst,
  output logic [DATA_W-1:0]  alu_src,
  output logic [FIELD_W-1:0] alu_oper,
  output logic [FIELD_W-1:0] alu_func,
  output logic [FIELD_W-1:0] alu_cond,
  output logic [PSR_W-1:0]   alu_psr,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [PSR_W-1:0]   alu_psr_wr,
  input  logic [PSR_W-1:0]   alu_psr_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [FIELD_W-1:0] out_wreg,
  output logic               out_wr,
  output logic               out_pc,
  output logic [PSR_W-1:0]   psr
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  seq_state_e         state_q, state_d;
  op_t                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PSR_W-1:0]   psr_q, psr_d;
  logic [DATA_W-1:0]  out_result_q, out_result_d;
  logic [FIELD_W-1:0] out_wreg_q, out_wreg_d;
  logic               out_wr_q, out_wr_d;
  logic               out_pc_q, out_pc_d;

  logic accept;
  logic capture;
  logic dec_wr;
  logic dec_pc;
  logic dec_mul;

  alu_seq_dec u_dec (
    .oper_i (in_oper),
    .func_i (in_func),
    .wr_o   (dec_wr),
    .pc_o   (dec_pc),
    .mul_o  (dec_mul)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // Retiring frees the operand registers, so a waiting op is taken the same cycle.
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Never signal a completed handshake while reset is discarding it.
    if (reset) in_ready = 1'b0;
    accept = in_ready && in_valid;
  end

  always_comb begin
    op_d         = op_q;
    cnt_d        = cnt_q;
    psr_d        = psr_q;
    out_result_d = out_result_q;
    out_wreg_d   = out_wreg_q;
    out_wr_d     = out_wr_q;
    out_pc_d     = out_pc_q;
    if (accept) begin
      op_d  = '{oper: in_oper, func: in_func, cond: in_cond, dst: in_dst,
                src: in_src, wreg: in_wreg, wr: dec_wr, pc: dec_pc};
      cnt_d = dec_mul ? MUL_LOAD : '0;
    end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (capture) begin
      out_result_d = alu_result;
      out_wreg_d   = op_q.wreg;
      out_wr_d     = op_q.wr;
      out_pc_d     = op_q.pc;
      psr_d        = psr_merge(psr_q, alu_psr_wr, alu_psr_en);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the datapath registers are all cleared because they drive module outputs directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      cnt_q        <= '0;
      psr_q        <= '0;
      out_result_q <= '0;
      out_wreg_q   <= '0;
      out_wr_q     <= 1'b0;
      out_pc_q     <= 1'b0;
    end else begin
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      psr_q        <= psr_d;
      out_result_q <= out_result_d;
      out_wreg_q   <= out_wreg_d;
      out_wr_q     <= out_wr_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign alu_dst    = op_q.dst;
  assign alu_src    = op_q.src;
  assign alu_oper   = op_q.oper;
  assign alu_func   = op_q.func;
  assign alu_cond   = op_q.cond;
  assign alu_psr    = psr_q;
  assign psr        = psr_q;
  assign out_result = out_result_q;
  assign out_wreg   = out_wreg_q;
  assign out_wr     = out_wr_q;
  assign out_pc     = out_pc_q;

endmodule
